uart_rx_8bytes: RTL and testbench

Receiver for the 8-byte RS485 serial packet: start bit 0, 8 data bits LSB first, stop bit 1, at least one idle bit between bytes, eight bytes per packet.
Oversamples the line, deserializes each byte and assembles the packet.
Presents all 64 bits in parallel with a one-cycle valid strobe.
Sits behind the RS485 transceiver RX pin on the receiving board; clk is an integer multiple of the line baud rate, asynchronous to the sender.

---
 rtl/uart_rx_8bytes_pkg.sv | 22 ++
 rtl/uart_rx_8bytes_byte.sv | 127 ++++++++++++
 rtl/uart_rx_8bytes.sv | 97 +++++++++
 tb/tb_uart_rx_8bytes.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_8bytes_pkg.sv
// Shared definitions for the 8-byte RS485 packet receiver: receiver FSM
// state codes and the default packet geometry.
package uart_rx_8bytes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   localparam int UART_NBYTES   = 8;
   localparam int UART_OVS      = 8;
   localparam int UART_GAP_BITS = 16;

   // Number of idle clock cycles that abandons a partially received packet.
   function automatic int gap_cycles(input int ovs, input int gap_bits);
      return ovs * gap_bits;
   endfunction

endpackage

// File: rtl/uart_rx_8bytes_byte.sv
// Single-byte UART receiver: synchronises rx, confirms the start bit at
// mid-bit, shifts in 8 data bits LSB first and checks the stop bit.
// byte_ok/byte_err/start_ok are combinational strobes that are active on
// the sampling cycle itself.
module uart_rx_byte
   import uart_rx_8bytes_pkg::*;
#(
   parameter int OVS = UART_OVS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_ok,
   output logic       byte_err,
   output logic       start_ok,
   output logic       idle
);

   localparam int CW = $clog2(OVS);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);

   logic          rx_m;
   logic          rx_s;
   rx_state_t     state_q;
   rx_state_t     state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [2:0]    bit_q;
   logic [2:0]    bit_d;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;

   // Two-flop synchroniser; the line idles high so the flops reset to 1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // State, oversampling counter, bit index and shift register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Next-state logic; the counter free-runs and is cleared at each sample.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      byte_ok  = 1'b0;
      byte_err = 1'b0;
      start_ok = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d  = ST_DATA;
                  bit_d    = '0;
                  start_ok = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_ok = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  byte_err = 1'b1;
                  state_d  = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign rx_byte = shift_q;
   assign idle    = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_rx_8bytes.sv
// 8-byte packet receiver: collects bytes from uart_rx_byte into a buffer,
// publishes the whole packet at once, and aborts partial packets on a bad
// stop bit or an over-long idle gap between bytes.
module uart_rx_8bytes
   import uart_rx_8bytes_pkg::*;
#(
   parameter int OVS      = UART_OVS,
   parameter int NBYTES   = UART_NBYTES,
   parameter int GAP_BITS = UART_GAP_BITS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rx,
   output logic [8*NBYTES-1:0]        pkt_data,
   output logic                       pkt_valid,
   output logic                       frame_err,
   output logic                       busy,
   output logic [$clog2(NBYTES)-1:0]  byte_cnt
);

   localparam int BCW     = $clog2(NBYTES);
   localparam int GAP_CYC = gap_cycles(OVS, GAP_BITS);
   localparam int GW      = $clog2(GAP_CYC);

   logic [7:0]              rx_byte;
   logic                    byte_ok;
   logic                    byte_err;
   logic                    start_ok;
   logic                    idle;
   logic [8*(NBYTES-1)-1:0] byte_buf;
   logic [GW-1:0]           gap_cnt;
   logic                    gap_run;
   logic                    gap_hit;
   logic                    last_byte;

   uart_rx_byte #(
      .OVS(OVS)
   ) u_byte (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .rx_byte (rx_byte),
      .byte_ok (byte_ok),
      .byte_err(byte_err),
      .start_ok(start_ok),
      .idle    (idle)
   );

   assign gap_run   = idle && (byte_cnt != '0);
   assign gap_hit   = gap_run && (gap_cnt == GW'(GAP_CYC - 1));
   assign last_byte = (byte_cnt == BCW'(NBYTES - 1));

   // Counts idle cycles inside a packet; cleared whenever the receiver leaves IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gap_cnt <= '0;
      end else if (!gap_run || gap_hit) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end

   // Packet assembly; the final byte goes straight into pkt_data with the buffer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         byte_cnt  <= '0;
         byte_buf  <= '0;
         pkt_data  <= '0;
         pkt_valid <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         pkt_valid <= 1'b0;
         frame_err <= 1'b0;
         if (start_ok) begin
            busy <= 1'b1;
         end
         if (byte_ok) begin
            if (last_byte) begin
               pkt_data  <= {rx_byte, byte_buf};
               pkt_valid <= 1'b1;
               byte_cnt  <= '0;
               busy      <= 1'b0;
            end else begin
               byte_buf[{byte_cnt, 3'b000} +: 8] <= rx_byte;
               byte_cnt <= byte_cnt + 1'b1;
            end
         end else if (byte_err || gap_hit) begin
            frame_err <= 1'b1;
            byte_cnt  <= '0;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_8bytes.sv
// Self-checking bench for uart_rx_8bytes: a serial sender drives rx, the
// expected events are queued as packets are sent, and a monitor pops and
// compares whenever the DUT strobes pkt_valid or frame_err.
module tb_uart_rx_8bytes;

   localparam int OVS      = 8;
   localparam int NBYTES   = 8;
   localparam int GAP_BITS = 16;
   localparam int CLK_HALF = 50;
   localparam int BIT_NOM  = OVS * 2 * CLK_HALF;
   localparam int BIT_FAST = 784;
   localparam int BIT_SLOW = 816;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx = 1'b1;
   logic [63:0] pkt_data;
   logic        pkt_valid;
   logic        frame_err;
   logic        busy;
   logic [2:0]  byte_cnt;

   typedef struct {
      bit          is_err;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   uart_rx_8bytes #(
      .OVS(OVS),
      .NBYTES(NBYTES),
      .GAP_BITS(GAP_BITS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .pkt_data (pkt_data),
      .pkt_valid(pkt_valid),
      .frame_err(frame_err),
      .busy     (busy),
      .byte_cnt (byte_cnt)
   );

   // Free-running receiver clock.
   always #CLK_HALF clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Serial frame: start 0, 8 bits LSB first, stop bit, back to idle high.
   task automatic send_byte(input logic [7:0] b, input logic stop, input int bp);
      rx = 1'b0;
      #bp;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #bp;
      end
      rx = stop;
      #bp;
      rx = 1'b1;
   endtask

   // Sends a whole packet (byte 0 first) and queues the expected packet.
   task automatic apply_stimulus(input logic [63:0] pkt, input int bp, input int extra_max);
      exp_t e;
      e.is_err = 1'b0;
      e.data   = pkt;
      exp_q.push_back(e);
      for (int k = 0; k < NBYTES; k++) begin
         send_byte(pkt[8*k +: 8], 1'b1, bp);
         #(bp * (1 + $urandom_range(0, extra_max)));
      end
   endtask

   task automatic expect_error();
      exp_t e;
      e.is_err = 1'b1;
      e.data   = '0;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL %s: %0d events outstanding after %0d cycles, expected 0", name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   function automatic logic [63:0] rand_pkt();
      return {$urandom(), $urandom()};
   endfunction

   // Scoreboard monitor: every DUT strobe must match the head of the queue.
   always @(negedge clk) begin
      if (reset) begin
         if (pkt_valid && frame_err) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL strobe_overlap: pkt_valid=1 frame_err=1, expected not both");
         end else if (pkt_valid || frame_err) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL unexpected_event: pkt_valid=%0b frame_err=%0b data=%h, expected none",
                        pkt_valid, frame_err, pkt_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_err != frame_err) begin
                  miscompares++;
                  $display("[TB] FAIL event_kind: frame_err=%0b expected %0b", frame_err, mon_e.is_err);
               end else if (!mon_e.is_err && pkt_data !== mon_e.data) begin
                  miscompares++;
                  $display("[TB] FAIL pkt_data: got %h expected %h", pkt_data, mon_e.data);
               end
            end
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #50_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios interleaved with randomised packets.
   initial begin
      logic [63:0] p;
      logic        busy_seen;

      reset = 1'b0;
      rx    = 1'b1;
      repeat (4) @(negedge clk);
      check_output("reset_pkt_data", pkt_data, 64'h0);
      check_output("reset_pkt_valid", 64'(pkt_valid), 64'h0);
      check_output("reset_frame_err", 64'(frame_err), 64'h0);
      check_output("reset_busy", 64'(busy), 64'h0);
      check_output("reset_byte_cnt", 64'(byte_cnt), 64'h0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      #37;

      $display("[TB] incrementing packet");
      apply_stimulus(64'h0807060504030201, BIT_NOM, 0);
      wait_drain("drain_incr", 200);

      $display("[TB] bad stop bit on byte 3");
      expect_error();
      send_byte(8'h11, 1'b1, BIT_NOM); #BIT_NOM;
      send_byte(8'h22, 1'b1, BIT_NOM); #BIT_NOM;
      send_byte(8'h33, 1'b1, BIT_NOM); #BIT_NOM;
      send_byte(8'h44, 1'b0, BIT_NOM);
      #(3 * BIT_NOM);
      wait_drain("drain_stop_err", 200);
      check_output("stop_err_byte_cnt", 64'(byte_cnt), 64'h0);
      check_output("stop_err_busy", 64'(busy), 64'h0);
      apply_stimulus(64'hA5A5A5A5A5A5A5A5, BIT_NOM, 0);
      wait_drain("drain_a5", 200);

      $display("[TB] start glitch");
      @(negedge clk);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      busy_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         busy_seen = busy_seen | busy;
      end
      check_output("glitch_busy", 64'(busy_seen), 64'h0);
      apply_stimulus(rand_pkt(), BIT_NOM, 2);
      wait_drain("drain_after_glitch", 200);

      $display("[TB] gap timeout");
      expect_error();
      send_byte(8'h5A, 1'b1, BIT_NOM); #BIT_NOM;
      send_byte(8'hC3, 1'b1, BIT_NOM); #BIT_NOM;
      send_byte(8'h3C, 1'b1, BIT_NOM);
      #(20 * BIT_NOM);
      wait_drain("drain_gap", 200);
      check_output("gap_byte_cnt", 64'(byte_cnt), 64'h0);
      check_output("gap_busy", 64'(busy), 64'h0);
      apply_stimulus(64'h002449_6D92B6DBFF, BIT_NOM, 0);
      wait_drain("drain_desc", 200);

      $display("[TB] random packets");
      for (int n = 0; n < 4; n++) begin
         #($urandom_range(0, 99));
         apply_stimulus(rand_pkt(), BIT_NOM, 3);
         wait_drain("drain_random", 200);
      end

      $display("[TB] reset inside byte 6");
      p = rand_pkt();
      for (int k = 0; k < 6; k++) begin
         send_byte(p[8*k +: 8], 1'b1, BIT_NOM);
         #BIT_NOM;
      end
      p[55:48] = p[55:48] | 8'h20;
      rx = 1'b0;
      #BIT_NOM;
      for (int i = 0; i < 5; i++) begin
         rx = p[48 + i];
         #BIT_NOM;
      end
      rx = 1'b1;
      #(BIT_NOM / 2);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_output("midreset_pkt_data", pkt_data, 64'h0);
      check_output("midreset_busy", 64'(busy), 64'h0);
      check_output("midreset_byte_cnt", 64'(byte_cnt), 64'h0);
      #(3 * BIT_NOM);
      apply_stimulus(rand_pkt(), BIT_NOM, 1);
      wait_drain("drain_after_reset", 200);

      $display("[TB] back-to-back packets, sender 2%% slow and 2%% fast");
      apply_stimulus(rand_pkt(), BIT_SLOW, 0);
      apply_stimulus(rand_pkt(), BIT_SLOW, 0);
      wait_drain("drain_slow", 200);
      apply_stimulus(rand_pkt(), BIT_FAST, 0);
      apply_stimulus(rand_pkt(), BIT_FAST, 0);
      wait_drain("drain_fast", 200);

      repeat (20) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
